// File: rtl/data_mem_bridge.sv
//------------------------------------------------------------------------------
// Module   : data_mem_bridge
// Purpose  : MEM-stage data port bridge. Steers CPU loads/stores to the data
//            SRAM (1-cycle read) or the confreg bus (req/ack), builds byte
//            strobes and lane-replicated store data, extends load data,
//            stalls the pipeline while an access is outstanding and counts
//            misaligned accesses and confreg timeouts.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_bridge #(
  parameter logic [31:0] CONF_BASE    = 32'h1faf0000,
  parameter logic [31:0] CONF_MASK    = 32'hffff0000,
  parameter int          CONF_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_lsop_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_rvalid_o,
  output logic        stall_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic [7:0]  err_cnt_o,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  output logic        conf_req,
  output logic        conf_wr,
  output logic [3:0]  conf_wstrb,
  output logic [31:0] conf_addr,
  output logic [31:0] conf_wdata,
  input  logic        conf_ack,
  input  logic [31:0] conf_rdata
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam int            TW   = $clog2(CONF_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(CONF_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SRAM_RD   = 2'd1,
    CONF_WAIT = 2'd2
  } state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_lsop;
  logic [1:0]    r_off;
  logic [31:0]   r_addr;
  logic          r_wr;
  logic [3:0]    r_wstrb;
  logic [31:0]   r_wdata;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_err_cnt;

  logic [31:0] w_paddr;
  logic        w_conf_hit;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_misalign;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic        w_latch;
  logic        w_err_inc;

  // Sign/zero extension of a loaded word using the byte offset of the access.
  function automatic logic [31:0] extend(input logic [3:0] op, input logic [1:0] off,
                                         input logic [31:0] word);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   extend = {{24{b[7]}}, b};
      OP_LBU:  extend = {24'h0, b};
      OP_LH:   extend = {{16{h[15]}}, h};
      OP_LHU:  extend = {16'h0, h};
      OP_LW:   extend = word;
      default: extend = 32'h0;
    endcase
  endfunction

  // Request decode: kseg-style translation clears the top three address bits.
  assign w_paddr    = cpu_addr_i & 32'h1fff_ffff;
  assign w_conf_hit = (w_paddr & CONF_MASK) == CONF_BASE;
  assign w_is_load  = !cpu_we_i && (cpu_lsop_i >= OP_LB) && (cpu_lsop_i <= OP_LW);
  assign w_is_store =  cpu_we_i && (cpu_lsop_i >= OP_SB) && (cpu_lsop_i <= OP_SW);

  // Alignment check, write strobes and lane-replicated store data.
  always_comb begin
    w_misalign = 1'b0;
    w_strb     = 4'b0000;
    w_wdata    = 32'h0;
    case (cpu_lsop_i)
      OP_LH, OP_LHU: w_misalign = cpu_addr_i[0];
      OP_LW:         w_misalign = |cpu_addr_i[1:0];
      OP_SB: begin
        w_strb  = 4'b0001 << cpu_addr_i[1:0];
        w_wdata = {4{cpu_wdata_i[7:0]}};
      end
      OP_SH: begin
        w_misalign = cpu_addr_i[0];
        w_strb     = cpu_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{cpu_wdata_i[15:0]}};
      end
      OP_SW: begin
        w_misalign = |cpu_addr_i[1:0];
        w_strb     = 4'b1111;
        w_wdata    = cpu_wdata_i;
      end
      default: ;
    endcase
  end

  // Next-state and output decode; everything is forced quiet while rst is high.
  always_comb begin
    w_next          = r_state;
    w_latch         = 1'b0;
    w_err_inc       = 1'b0;
    cpu_rdata_o     = 32'h0;
    cpu_rvalid_o    = 1'b0;
    stall_o         = 1'b0;
    adel_o          = 1'b0;
    ades_o          = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (cpu_ce_i && (w_is_load || w_is_store)) begin
            if (w_misalign) begin
              adel_o    = w_is_load;
              ades_o    = w_is_store;
              w_err_inc = 1'b1;
            end else if (w_conf_hit) begin
              stall_o = 1'b1;
              w_latch = 1'b1;
              w_next  = CONF_WAIT;
            end else if (w_is_store) begin
              data_sram_en    = 1'b1;
              data_sram_wen   = w_strb;
              data_sram_addr  = w_paddr;
              data_sram_wdata = w_wdata;
            end else begin
              data_sram_en   = 1'b1;
              data_sram_addr = w_paddr;
              stall_o        = 1'b1;
              w_latch        = 1'b1;
              w_next         = SRAM_RD;
            end
          end
        end
        SRAM_RD: begin
          cpu_rvalid_o = 1'b1;
          cpu_rdata_o  = extend(r_lsop, r_off, data_sram_rdata);
          w_next       = IDLE;
        end
        CONF_WAIT: begin
          if (conf_ack) begin
            cpu_rvalid_o = !r_wr;
            cpu_rdata_o  = r_wr ? 32'h0 : extend(r_lsop, r_off, conf_rdata);
            w_next       = IDLE;
          end else if (r_timer == TMAX) begin
            // Abort: loads still complete, returning zero.
            cpu_rvalid_o = !r_wr;
            w_err_inc    = 1'b1;
            w_next       = IDLE;
          end else begin
            stall_o = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Confreg request is held stable from the latched copy for the whole wait.
  assign conf_req   = (r_state == CONF_WAIT) && !rst;
  assign conf_wr    = r_wr;
  assign conf_wstrb = r_wstrb;
  assign conf_addr  = r_addr;
  assign conf_wdata = r_wdata;
  assign err_cnt_o  = r_err_cnt;

  // State, latched request, timeout timer and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lsop    <= 4'h0;
      r_off     <= 2'b00;
      r_addr    <= 32'h0;
      r_wr      <= 1'b0;
      r_wstrb   <= 4'h0;
      r_wdata   <= 32'h0;
      r_timer   <= '0;
      r_err_cnt <= 8'h0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_lsop  <= cpu_lsop_i;
        r_off   <= cpu_addr_i[1:0];
        r_addr  <= w_paddr;
        r_wr    <= w_is_store;
        r_wstrb <= w_strb;
        r_wdata <= w_wdata;
      end
      r_timer <= (r_state == CONF_WAIT && w_next == CONF_WAIT) ? r_timer + TW'(1) : '0;
      if (w_err_inc && r_err_cnt != 8'hff)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_bridge.sv
//------------------------------------------------------------------------------
// Module   : tb_data_mem_bridge
// Purpose  : Self-checking bench for data_mem_bridge with an SRAM model, a
//            per-request confreg responder and a load-data scoreboard.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i;
  logic [3:0]  cpu_lsop_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_rvalid_o, stall_o, adel_o, ades_o;
  logic [7:0]  err_cnt_o;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        conf_req, conf_wr, conf_ack;
  logic [3:0]  conf_wstrb;
  logic [31:0] conf_addr, conf_wdata, conf_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem [0:255];

  // Values captured during the most recent request.
  logic        cap_en, cap_adel, cap_ades, cap_cwr;
  logic [3:0]  cap_wen, cap_cstrb;
  logic [31:0] cap_addr, cap_wdata, cap_caddr, cap_cwdata;
  int          cap_stalls, cap_creq;

  data_mem_bridge dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_lsop_i(cpu_lsop_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o), .stall_o(stall_o),
    .adel_o(adel_o), .ades_o(ades_o), .err_cnt_o(err_cnt_o),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .conf_req(conf_req), .conf_wr(conf_wr), .conf_wstrb(conf_wstrb),
    .conf_addr(conf_addr), .conf_wdata(conf_wdata),
    .conf_ack(conf_ack), .conf_rdata(conf_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // SRAM model: 1-cycle read latency, byte-strobed writes.
  always @(posedge clk) begin
    if (data_sram_en) begin
      data_sram_rdata <= mem[data_sram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (data_sram_wen[b]) mem[data_sram_addr[9:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
    end
  end

  // Scoreboard: every rvalid pops the oldest expected load result.
  always @(negedge clk) begin
    if (cpu_rvalid_o) begin
      if (exp_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
      else                   check("rdata", cpu_rdata_o, exp_q.pop_front());
    end
  end

  // Presents one request and holds it until stall drops; ack_at < 0 = no ack.
  task automatic do_req(input logic we, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] ack_data);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_lsop_i = op; cpu_addr_i = addr; cpu_wdata_i = wd;
    cap_stalls = 0; cap_creq = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      conf_ack   = (ack_at >= 0) && (cyc == ack_at);
      conf_rdata = conf_ack ? ack_data : 32'h0;
      #3;
      if (cyc == 0) begin
        cap_en = data_sram_en; cap_wen = data_sram_wen; cap_addr = data_sram_addr;
        cap_wdata = data_sram_wdata; cap_adel = adel_o; cap_ades = ades_o;
      end
      if (cyc == 1) begin
        cap_caddr = conf_addr; cap_cstrb = conf_wstrb; cap_cwr = conf_wr; cap_cwdata = conf_wdata;
      end
      if (conf_req) cap_creq++;
      if (stall_o) cap_stalls++;
      else         done = 1'b1;
    end
    if (!done) check("stall_bound", 32'd0, 32'd1);
    @(posedge clk); #1;
    cpu_ce_i = 1'b0; conf_ack = 1'b0; conf_rdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1; cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'h0;
    cpu_wdata_i = 32'h0; cpu_lsop_i = 4'h0; conf_ack = 1'b0; conf_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_stall", {31'h0, stall_o}, 32'd0);
    check("rst_rvalid", {31'h0, cpu_rvalid_o}, 32'd0);
    check("rst_err_cnt", {24'h0, err_cnt_o}, 32'd0);
    check("rst_conf_req", {31'h0, conf_req}, 32'd0);
    check("rst_sram_en", {31'h0, data_sram_en}, 32'd0);
    rst = 1'b0;

    // SRAM word store then load.
    do_req(1'b1, 4'd8, 32'h8000_0010, 32'h1234_5678, -1, 32'h0);
    check("sw_en", {31'h0, cap_en}, 32'd1);
    check("sw_wen", {28'h0, cap_wen}, 32'hf);
    check("sw_addr", cap_addr, 32'h0000_0010);
    check("sw_wdata", cap_wdata, 32'h1234_5678);
    check("sw_stalls", cap_stalls, 32'd0);
    exp_q.push_back(32'h1234_5678);
    do_req(1'b0, 4'd5, 32'h8000_0010, 32'h0, -1, 32'h0);
    check("lw_stalls", cap_stalls, 32'd1);
    check("lw_en", {31'h0, cap_en}, 32'd1);
    check("lw_wen", {28'h0, cap_wen}, 32'h0);

    // Byte store to lane 3, then signed/unsigned byte loads.
    do_req(1'b1, 4'd6, 32'h8000_0013, 32'h0000_00ab, -1, 32'h0);
    check("sb_wen", {28'h0, cap_wen}, 32'h8);
    check("sb_wdata", cap_wdata, 32'habab_abab);
    exp_q.push_back(32'hffff_ffab);
    do_req(1'b0, 4'd1, 32'h8000_0013, 32'h0, -1, 32'h0);
    exp_q.push_back(32'h0000_00ab);
    do_req(1'b0, 4'd2, 32'h8000_0013, 32'h0, -1, 32'h0);

    // Halfword loads from the upper half of 0x80010000.
    do_req(1'b1, 4'd8, 32'h8000_0000, 32'h8001_0000, -1, 32'h0);
    exp_q.push_back(32'hffff_8001);
    do_req(1'b0, 4'd3, 32'h8000_0002, 32'h0, -1, 32'h0);
    exp_q.push_back(32'h0000_8001);
    do_req(1'b0, 4'd4, 32'h8000_0002, 32'h0, -1, 32'h0);

    // Misaligned accesses.
    do_req(1'b0, 4'd3, 32'h8000_0001, 32'h0, -1, 32'h0);
    check("adel", {31'h0, cap_adel}, 32'd1);
    check("adel_no_en", {31'h0, cap_en}, 32'd0);
    check("adel_stalls", cap_stalls, 32'd0);
    check("err_cnt_1", {24'h0, err_cnt_o}, 32'd1);
    do_req(1'b1, 4'd7, 32'h8000_0003, 32'h0, -1, 32'h0);
    check("ades_sh", {31'h0, cap_ades}, 32'd1);
    do_req(1'b1, 4'd8, 32'h8000_0002, 32'h0, -1, 32'h0);
    check("ades_sw", {31'h0, cap_ades}, 32'd1);
    check("err_cnt_3", {24'h0, err_cnt_o}, 32'd3);

    // Upper-half store, then halfword and byte loads of it.
    do_req(1'b1, 4'd7, 32'h8000_0006, 32'h1234_beef, -1, 32'h0);
    check("sh_wen", {28'h0, cap_wen}, 32'hc);
    check("sh_wdata", cap_wdata, 32'hbeef_beef);
    exp_q.push_back(32'h0000_beef);
    do_req(1'b0, 4'd4, 32'h8000_0006, 32'h0, -1, 32'h0);
    exp_q.push_back(32'hffff_ffbe);
    do_req(1'b0, 4'd1, 32'h8000_0007, 32'h0, -1, 32'h0);

    // Confreg accesses with acknowledgement.
    exp_q.push_back(32'h0000_cafe);
    do_req(1'b0, 4'd5, 32'hbfaf_8000, 32'h0, 3, 32'h0000_cafe);
    check("conf_lw_stalls", cap_stalls, 32'd3);
    check("conf_lw_req", cap_creq, 32'd3);
    check("conf_lw_addr", cap_caddr, 32'h1faf_8000);
    check("conf_lw_wr", {31'h0, cap_cwr}, 32'd0);
    check("conf_lw_no_sram", {31'h0, cap_en}, 32'd0);
    exp_q.push_back(32'hffff_ff80);
    do_req(1'b0, 4'd1, 32'hbfaf_8001, 32'h0, 1, 32'h0000_8000);
    check("conf_lb_stalls", cap_stalls, 32'd1);
    do_req(1'b1, 4'd7, 32'hbfaf_8002, 32'h0000_1234, 2, 32'h0);
    check("conf_sh_stalls", cap_stalls, 32'd2);
    check("conf_sh_strb", {28'h0, cap_cstrb}, 32'hc);
    check("conf_sh_wdata", cap_cwdata, 32'h1234_1234);
    check("conf_sh_wr", {31'h0, cap_cwr}, 32'd1);

    // Confreg timeouts.
    do_req(1'b1, 4'd8, 32'hbfaf_8004, 32'h5555_aaaa, -1, 32'h0);
    check("tmo_sw_req", cap_creq, 32'd255);
    check("tmo_sw_stalls", cap_stalls, 32'd255);
    check("tmo_sw_strb", {28'h0, cap_cstrb}, 32'hf);
    check("err_cnt_4", {24'h0, err_cnt_o}, 32'd4);
    check("tmo_sw_req_drop", {31'h0, conf_req}, 32'd0);
    exp_q.push_back(32'h0);
    do_req(1'b0, 4'd5, 32'hbfaf_8008, 32'h0, -1, 32'h0);
    check("err_cnt_5", {24'h0, err_cnt_o}, 32'd5);

    // Undefined opcodes are no-ops.
    do_req(1'b0, 4'd0, 32'h8000_0010, 32'h0, -1, 32'h0);
    check("nop0_en", {31'h0, cap_en}, 32'd0);
    check("nop0_stalls", cap_stalls, 32'd0);
    do_req(1'b1, 4'd9, 32'hbfaf_8000, 32'h0, -1, 32'h0);
    check("nop9_en", {31'h0, cap_en}, 32'd0);
    check("nop9_req", cap_creq, 32'd0);
    check("nop_err_cnt", {24'h0, err_cnt_o}, 32'd5);

    // Reset while waiting on confreg.
    @(posedge clk); #1;
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_lsop_i = 4'd5; cpu_addr_i = 32'hbfaf_800c;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_req", {31'h0, conf_req}, 32'd1);
    rst = 1'b1; cpu_ce_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    check("mid_rst_req", {31'h0, conf_req}, 32'd0);
    check("mid_rst_stall", {31'h0, stall_o}, 32'd0);
    check("mid_rst_err", {24'h0, err_cnt_o}, 32'd0);

    repeat (3) @(posedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
